// File: rtl/adc_axis_source.sv
// Zmod ADC capture: sign-extends paired 14-bit samples into 32-bit AXI-Stream words,
// decimates, and buffers them in a first-word-fall-through FIFO gated by IAGC status.
module adc_axis_source #(
    parameter int ZMOD_DATA_SIZE   = 14,
    parameter int AXIS_DATA_SIZE   = 32,
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int FIFO_DEPTH_LOG2  = 4,
    parameter int OVF_COUNT_SIZE   = 16
) (
    input  logic                        i_sys_clock,
    input  logic                        i_rst_n,
    input  logic [IAGC_STATUS_SIZE-1:0] i_iagc_status,
    input  logic [ZMOD_DATA_SIZE-1:0]   i_adc_ch1,
    input  logic [ZMOD_DATA_SIZE-1:0]   i_adc_ch2,
    input  logic                        i_adc_valid,
    input  logic [7:0]                  i_decimation,
    input  logic                        i_clear_overflow,
    output logic [AXIS_DATA_SIZE-1:0]   o_data,
    output logic                        o_data_valid,
    input  logic                        i_data_ready,
    output logic [FIFO_DEPTH_LOG2:0]    o_fifo_level,
    output logic                        o_overflow,
    output logic [OVF_COUNT_SIZE-1:0]   o_overflow_count
);

    localparam int HALF  = AXIS_DATA_SIZE / 2;
    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_LEVEL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2:0] ONE_LEVEL  = (FIFO_DEPTH_LOG2 + 1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                       state, state_next;
    logic [AXIS_DATA_SIZE-1:0]    mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]     level;
    logic [7:0]                   dec_cnt, dec_cnt_next;
    logic                         ovf;
    logic [OVF_COUNT_SIZE-1:0]    ovf_cnt;
    logic                         empty, full, pop, keep, push, drop;
    logic signed [HALF-1:0]       ch1_ext, ch2_ext;
    logic [AXIS_DATA_SIZE-1:0]    word;

    function automatic logic signed [HALF-1:0] sext(input logic signed [ZMOD_DATA_SIZE-1:0] s);
        return HALF'(s);
    endfunction

    function automatic logic [OVF_COUNT_SIZE-1:0] sat_inc(input logic [OVF_COUNT_SIZE-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign ch1_ext = sext(i_adc_ch1);
    assign ch2_ext = sext(i_adc_ch2);
    assign word    = {ch2_ext, ch1_ext};

    assign empty = (level == '0);
    assign full  = (level == FULL_LEVEL);
    assign pop   = !empty && i_data_ready;
    assign keep  = (state == RUN) && i_adc_valid && (dec_cnt == 8'd0);
    // A pop frees the slot in the same cycle, so a push at full still succeeds.
    assign push  = keep && (!full || pop);
    assign drop  = keep && full && !pop;

    always_comb begin
        dec_cnt_next = dec_cnt;
        if (state != RUN)
            dec_cnt_next = 8'd0;
        else if (i_adc_valid)
            dec_cnt_next = (dec_cnt >= i_decimation) ? 8'd0 : dec_cnt + 8'd1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_iagc_status != '0) state_next = RUN;
            RUN:     if (i_iagc_status == '0) state_next = DRAIN;
            DRAIN: begin
                if (i_iagc_status != '0)
                    state_next = RUN;
                else if (empty || (level == ONE_LEVEL && pop))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            dec_cnt <= 8'd0;
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else begin
            state   <= state_next;
            dec_cnt <= dec_cnt_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // Clear wins over a drop in the same cycle.
            if (i_clear_overflow) begin
                ovf     <= 1'b0;
                ovf_cnt <= '0;
            end else if (drop) begin
                ovf     <= 1'b1;
                ovf_cnt <= sat_inc(ovf_cnt);
            end
        end
    end

    always_ff @(posedge i_sys_clock) begin
        if (push) mem[wr_ptr] <= word;
    end

    assign o_data           = empty ? '0 : mem[rd_ptr];
    assign o_data_valid     = !empty;
    assign o_fifo_level     = level;
    assign o_overflow       = ovf;
    assign o_overflow_count = ovf_cnt;

endmodule

// File: tb/tb_adc_axis_source.sv
// Bench for adc_axis_source: directed scenarios plus randomized traffic against a
// queue-based reference model of capture, decimation, FIFO and overflow behaviour.
module tb_adc_axis_source;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  status;
    logic [13:0] ch1, ch2;
    logic        adc_valid;
    logic [7:0]  dec;
    logic        clr;
    logic [31:0] data;
    logic        data_valid;
    logic        ready;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] overflow_count;

    always #5 clk = ~clk;

    adc_axis_source dut (
        .i_sys_clock      (clk),
        .i_rst_n          (rst_n),
        .i_iagc_status    (status),
        .i_adc_ch1        (ch1),
        .i_adc_ch2        (ch2),
        .i_adc_valid      (adc_valid),
        .i_decimation     (dec),
        .i_clear_overflow (clr),
        .o_data           (data),
        .o_data_valid     (data_valid),
        .i_data_ready     (ready),
        .o_fifo_level     (level),
        .o_overflow       (overflow),
        .o_overflow_count (overflow_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: capture enabled / draining flags, a word queue, a keep counter.
    logic [31:0] mq[$];
    bit          m_capture;
    bit          m_draining;
    int          m_skip;
    bit          m_ovf;
    int          m_ocnt;

    function automatic logic [31:0] pack(input logic [13:0] a, input logic [13:0] b);
        return {{2{b[13]}}, b, {2{a[13]}}, a};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_capture  = 0;
        m_draining = 0;
        m_skip     = 0;
        m_ovf      = 0;
        m_ocnt     = 0;
    endtask

    task automatic model_update();
        int sz;
        bit pop, kept;
        sz   = mq.size();
        pop  = (sz > 0) && ready;
        kept = m_capture && adc_valid && (m_skip == 0);
        if (pop) void'(mq.pop_front());
        if (kept) begin
            if (sz < DEPTH || pop) mq.push_back(pack(ch1, ch2));
            else if (!clr) begin
                m_ovf  = 1;
                m_ocnt = (m_ocnt < 65535) ? m_ocnt + 1 : 65535;
            end
        end
        if (clr) begin
            m_ovf  = 0;
            m_ocnt = 0;
        end
        if (!m_capture) m_skip = 0;
        else if (adc_valid) m_skip = (m_skip >= int'(dec)) ? 0 : m_skip + 1;
        if (m_capture) begin
            if (status == 0) begin m_capture = 0; m_draining = 1; end
        end else if (status != 0) begin
            m_capture = 1; m_draining = 0;
        end else if (m_draining && mq.size() == 0) begin
            m_draining = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"}, level, mq.size());
        chk({tag, ".valid"}, data_valid, mq.size() > 0);
        chk({tag, ".data"}, data, (mq.size() > 0) ? mq[0] : 32'h0);
        chk({tag, ".ovf"}, overflow, m_ovf);
        chk({tag, ".ocnt"}, overflow_count, m_ocnt);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic rnd_pair();
        ch1 = 14'($urandom);
        ch2 = 14'($urandom);
    endtask

    initial begin
        rst_n = 1'b0; status = 4'd0; ch1 = '0; ch2 = '0; adc_valid = 1'b0;
        dec = 8'd0; clr = 1'b0; ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        chk("reset.data0", data, 32'h0);
        rst_n = 1'b1;

        // 1: single pair, 1-cycle latency
        status = 4'd1;
        tick("t1.enter");
        adc_valid = 1'b1; ch1 = 14'h1FFF; ch2 = 14'h2000;
        tick("t1.push");
        chk("t1.word", data, 32'hE000_1FFF);
        chk("t1.vld", data_valid, 1'b1);
        adc_valid = 1'b0;
        tick("t1.pop");
        chk("t1.empty", level, 5'd0);

        // 2: overflow on stalled FIFO, then drain in order
        ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            adc_valid = 1'b1; rnd_pair();
            tick("t2.fill");
        end
        adc_valid = 1'b0;
        tick("t2.stall");
        chk("t2.level16", level, 5'd16);
        chk("t2.ovf", overflow, 1'b1);
        chk("t2.cnt4", overflow_count, 16'd4);
        ready = 1'b1;
        for (int i = 0; i < 16; i++) tick("t2.drain");
        chk("t2.level0", level, 5'd0);
        clr = 1'b1;
        tick("t2.clr");
        clr = 1'b0;

        // 3: decimation by 4
        dec = 8'd3; ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            adc_valid = 1'b1; ch1 = 14'(i); ch2 = 14'h0;
            tick("t3.in");
        end
        adc_valid = 1'b0;
        chk("t3.level3", level, 5'd3);
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t3.ch1", data[15:0], 16'(4 * i));
            tick("t3.out");
        end
        chk("t3.cnt0", overflow_count, 16'd0);
        dec = 8'd0;

        // 4: push+pop at full, clear coincident with a drop
        ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            adc_valid = 1'b1; rnd_pair();
            tick("t4.fill");
        end
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rnd_pair();
            tick("t4.flow");
            chk("t4.level16", level, 5'd16);
            chk("t4.noovf", overflow, 1'b0);
        end
        ready = 1'b0; clr = 1'b1; rnd_pair();
        tick("t4.clrdrop");
        chk("t4.clr.ovf", overflow, 1'b0);
        chk("t4.clr.cnt", overflow_count, 16'd0);
        clr = 1'b0; rnd_pair();
        tick("t4.drop");
        chk("t4.drop.cnt", overflow_count, 16'd1);
        adc_valid = 1'b0; ready = 1'b1;
        for (int i = 0; i < 16; i++) tick("t4.drain");

        // 5: drain mode ignores input; re-entry to RUN keeps contents
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            adc_valid = 1'b1; rnd_pair();
            tick("t5.fill");
        end
        adc_valid = 1'b0; status = 4'd0;
        tick("t5.drainent");
        adc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rnd_pair();
            tick("t5.ignored");
        end
        chk("t5.level8", level, 5'd8);
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rnd_pair();
            tick("t5.drain");
        end
        chk("t5.level0", level, 5'd0);
        status = 4'd2;
        tick("t5.rerun");
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rnd_pair();
            tick("t5.fill2");
        end
        adc_valid = 1'b0; status = 4'd0;
        tick("t5.drain2");
        ready = 1'b1;
        for (int i = 0; i < 3; i++) tick("t5.part");
        ready = 1'b0; status = 4'd1;
        tick("t5.back");
        chk("t5.level5", level, 5'd5);
        adc_valid = 1'b1; rnd_pair();
        tick("t5.push");
        chk("t5.level6", level, 5'd6);
        adc_valid = 1'b0; ready = 1'b1;
        for (int i = 0; i < 6; i++) tick("t5.empty");

        // 6: asynchronous reset mid-burst
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            adc_valid = 1'b1; rnd_pair();
            tick("t6.fill");
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6.async");
        chk("t6.vld0", data_valid, 1'b0);
        status = 4'd0; adc_valid = 1'b1; rnd_pair();
        @(negedge clk);
        rst_n = 1'b1;
        tick("t6.idle");
        chk("t6.idle.level", level, 5'd0);

        // Randomized traffic
        status = 4'd1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) status = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
            if ($urandom_range(0, 99) < 2) dec = 8'($urandom_range(0, 3));
            adc_valid = ($urandom_range(0, 99) < 70);
            ready     = ($urandom_range(0, 99) < 55);
            clr       = ($urandom_range(0, 99) < 2);
            rnd_pair();
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
